load_store_sequencer: RTL and testbench
=======================================

LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 SHALL have ports: req_valid in 1, request present; req_ready out 1, request accepted when both high at an edge.
REQ-004 SHALL have ports: req_microcode in mem_microcode_t, fields is_write, is_unsigned, op_size[1:0].
REQ-005 SHALL have ports: req_base in 32, base address; req_offset in 12, signed immediate; req_store_data in 32, store data.
REQ-006 SHALL have ports to the memory unit: mem_enable_n out 1; mem_microcode out mem_microcode_t; mem_addr out 32; mem_in out 32.
REQ-007 SHALL have ports from the memory unit: mem_out in 32, load data; mem_fault_num in 3, fault code.
REQ-008 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_data out 32; rsp_fault_num out 3; rsp_addr out 32, effective address.

Function
REQ-009 SHALL implement states IDLE, ACCESS, SAMPLE, RESP; no other reachable states.
REQ-010 SHALL drive req_ready = (state==IDLE) | (state==RESP & rsp_ready), and 0 while reset_n low.
REQ-011 SHALL, on acceptance, register microcode, store data and effective address = req_base + sign_extend(req_offset), modulo 2^32, wrapping with no fault.
REQ-012 SHALL enter ACCESS on the edge after acceptance, from IDLE or RESP.
REQ-013 SHALL drive mem_enable_n = 0 only in ACCESS and SAMPLE, and 1 in IDLE and RESP.
REQ-014 SHALL hold mem_microcode, mem_addr and mem_in constant from entry to ACCESS until exit from SAMPLE.
REQ-015 SHALL transition ACCESS -> SAMPLE unconditionally after one cycle.
REQ-016 SHALL, at the SAMPLE -> RESP edge, capture mem_fault_num into rsp_fault_num and mem_out into rsp_data.
REQ-017 SHALL force rsp_data = 0 when the access is a store, or when mem_fault_num[2] = 1.
REQ-018 SHALL assert rsp_valid only in RESP, and hold rsp_data/rsp_fault_num/rsp_addr stable while rsp_valid=1 & rsp_ready=0.
REQ-019 SHALL leave RESP when rsp_ready=1: to ACCESS if req_valid=1 (back-to-back), else to IDLE.
REQ-020 SHALL ignore req_valid in ACCESS and SAMPLE; an in-flight access is never aborted, except by reset.
REQ-021 SHALL give latency of exactly 3 cycles from acceptance edge to first cycle with rsp_valid=1, and sustained throughput of one access per 3 cycles.
REQ-022 SHALL pass fault codes through unmodified: 100 load misaligned, 110 store misaligned, 101 load access fault, 111 store access fault, 0xx none.
REQ-023 SHALL never perform alignment or address-range checks itself.

Reset
REQ-024 SHALL, on any edge with reset_n=0, enter IDLE with mem_enable_n=1, rsp_valid=0, rsp_data=0, rsp_fault_num=000, rsp_addr=0, registered microcode/address/data=0.
REQ-025 SHALL, on reset in ACCESS, SAMPLE or RESP, discard the access and produce no response.
REQ-026 SHALL set mem_enable_n=1 within the same reset edge; no memory-unit enable cycle overlaps reset.

Verification
REQ-027 SHALL cover: word load, base=0x20000000, offset=0x004, memory returns 0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_data=0xDEADBEEF, rsp_fault_num=000, rsp_addr=0x20000004.
REQ-028 SHALL cover: store, base=0x20000010, offset=0xFFC (-4) -> mem_addr=0x2000000C, stable over both enable cycles; rsp_data=0, rsp_fault_num=010.
REQ-029 SHALL cover: word load, base=0x20000001, offset=0, memory reports 100 -> rsp_fault_num=100, rsp_data=0.
REQ-030 SHALL cover: base=0xFFFFFFFF, offset=0x002 -> rsp_addr=0x00000001, no sequencer-generated fault.
REQ-031 SHALL cover: rsp_ready held 0 for 5 cycles with req_valid=1 -> response stable, mem_enable_n=1; at rsp_ready=1, next access enters ACCESS next edge.
REQ-032 SHALL cover: reset_n=0 for one edge while in SAMPLE -> next cycle IDLE, mem_enable_n=1, rsp_valid never asserted for that access.

Source files
------------

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: accepts one memory request at a time, computes the
// effective address, holds the access stable to the memory unit for two
// enable cycles, then presents the captured result until it is consumed.

package load_store_sequencer_pkg;
  typedef struct packed {
    logic       is_write;
    logic       is_unsigned;
    logic [1:0] op_size;
  } mem_microcode_t;
endpackage

// state  | meaning
// IDLE   | no access in flight, ready for a request
// ACCESS | first memory enable cycle, request registers drive the memory unit
// SAMPLE | second memory enable cycle, memory result captured on exit
// RESP   | response presented until rsp_ready; may accept the next request
module load_store_sequencer
  import load_store_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  mem_microcode_t req_microcode,
  input  logic [31:0]    req_base,
  input  logic [11:0]    req_offset,
  input  logic [31:0]    req_store_data,
  output logic           mem_enable_n,
  output mem_microcode_t mem_microcode,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_in,
  input  logic [31:0]    mem_out,
  input  logic [2:0]     mem_fault_num,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [31:0]    rsp_data,
  output logic [2:0]     rsp_fault_num,
  output logic [31:0]    rsp_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SAMPLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           accept;
  logic [31:0]    eff_addr;
  mem_microcode_t mc_q;
  logic [31:0]    addr_q;
  logic [31:0]    data_q;
  logic [31:0]    rsp_data_q;
  logic [2:0]     rsp_fault_q;

  // Effective address wraps modulo 2^32; range checking belongs to the memory unit.
  assign eff_addr = req_base + {{20{req_offset[11]}}, req_offset};
  assign accept   = req_valid & req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake/enable decode; reset forces the handshake and enable inactive.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_enable_n = 1'b1;
    rsp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        mem_enable_n = 1'b0;
        state_d      = SAMPLE;
      end
      SAMPLE: begin
        mem_enable_n = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_d = req_valid ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset_n) begin
      req_ready    = 1'b0;
      mem_enable_n = 1'b1;
    end
  end

  // Request registers: loaded only on acceptance so the memory unit sees a stable access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mc_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      mc_q   <= req_microcode;
      addr_q <= eff_addr;
      data_q <= req_store_data;
    end
  end

  // Response capture at SAMPLE exit; stores and faulting accesses return zero data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_data_q  <= '0;
      rsp_fault_q <= '0;
    end else if (state_q == SAMPLE) begin
      rsp_fault_q <= mem_fault_num;
      rsp_data_q  <= (mc_q.is_write || mem_fault_num[2]) ? 32'd0 : mem_out;
    end
  end

  assign mem_microcode = mc_q;
  assign mem_addr      = addr_q;
  assign mem_in        = data_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_fault_num = rsp_fault_q;
  assign rsp_addr      = addr_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer with hand-computed expectations.
module tb_load_store_sequencer;
  import load_store_sequencer_pkg::*;

  logic           clk;
  logic           reset_n;
  logic           req_valid;
  logic           req_ready;
  mem_microcode_t req_microcode;
  logic [31:0]    req_base;
  logic [11:0]    req_offset;
  logic [31:0]    req_store_data;
  logic           mem_enable_n;
  mem_microcode_t mem_microcode;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_in;
  logic [31:0]    mem_out;
  logic [2:0]     mem_fault_num;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_data;
  logic [2:0]     rsp_fault_num;
  logic [31:0]    rsp_addr;

  int total = 0;
  int bad   = 0;

  load_store_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_microcode  (req_microcode),
    .req_base       (req_base),
    .req_offset     (req_offset),
    .req_store_data (req_store_data),
    .mem_enable_n   (mem_enable_n),
    .mem_microcode  (mem_microcode),
    .mem_addr       (mem_addr),
    .mem_in         (mem_in),
    .mem_out        (mem_out),
    .mem_fault_num  (mem_fault_num),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_fault_num  (rsp_fault_num),
    .rsp_addr       (rsp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and the memory unit's answer for it.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] base,
                       input logic [11:0] off, input logic [31:0] sd,
                       input logic [31:0] mout, input logic [2:0] mf);
    req_valid                 = 1'b1;
    req_microcode.is_write    = w;
    req_microcode.is_unsigned = 1'b0;
    req_microcode.op_size     = sz;
    req_base                  = base;
    req_offset                = off;
    req_store_data            = sd;
    mem_out                   = mout;
    mem_fault_num             = mf;
  endtask

  // First edge is the acceptance edge; checks ACCESS, SAMPLE, then RESP.
  task automatic flow(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_in,
                      input logic [3:0] exp_mc, input logic [31:0] exp_data, input logic [2:0] exp_fault);
    tick();
    req_valid = 1'b0;
    chk({tag, "_acc_en"},   32'(mem_enable_n), 32'd0);
    chk({tag, "_acc_addr"}, mem_addr, exp_addr);
    chk({tag, "_acc_in"},   mem_in, exp_in);
    chk({tag, "_acc_mc"},   32'(mem_microcode), 32'(exp_mc));
    chk({tag, "_acc_rv"},   32'(rsp_valid), 32'd0);
    chk({tag, "_acc_rdy"},  32'(req_ready), 32'd0);
    tick();
    chk({tag, "_smp_en"},   32'(mem_enable_n), 32'd0);
    chk({tag, "_smp_addr"}, mem_addr, exp_addr);
    chk({tag, "_smp_in"},   mem_in, exp_in);
    chk({tag, "_smp_rv"},   32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_rsp_rv"},    32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_en"},    32'(mem_enable_n), 32'd1);
    chk({tag, "_rsp_data"},  rsp_data, exp_data);
    chk({tag, "_rsp_fault"}, 32'(rsp_fault_num), 32'(exp_fault));
    chk({tag, "_rsp_addr"},  rsp_addr, exp_addr);
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_microcode  = '0;
    req_base       = '0;
    req_offset     = '0;
    req_store_data = '0;
    mem_out        = '0;
    mem_fault_num  = '0;
    rsp_ready      = 1'b1;

    tick();
    tick();
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_en",  32'(mem_enable_n), 32'd1);
    reset_n = 1'b1;
    #1;
    chk("rst_rv",    32'(rsp_valid), 32'd0);
    chk("rst_data",  rsp_data, 32'd0);
    chk("rst_fault", 32'(rsp_fault_num), 32'd0);
    chk("rst_addr",  rsp_addr, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_idle_rdy", 32'(req_ready), 32'd1);

    // Word load, plain positive offset.
    issue(1'b0, 2'b10, 32'h2000_0000, 12'h004, 32'h0, 32'hDEAD_BEEF, 3'b000);
    flow("ld_word", 32'h2000_0004, 32'h0, 4'b0010, 32'hDEAD_BEEF, 3'b000);
    tick();
    chk("gap_rv",  32'(rsp_valid), 32'd0);
    chk("gap_rdy", 32'(req_ready), 32'd1);

    // Store with negative offset; memory reports non-fault code 010.
    issue(1'b1, 2'b10, 32'h2000_0010, 12'hFFC, 32'h1234_5678, 32'hCAFE_F00D, 3'b010);
    flow("st_neg", 32'h2000_000C, 32'h1234_5678, 4'b1010, 32'h0, 3'b010);

    // Back-to-back: misaligned load, memory faults with 100.
    issue(1'b0, 2'b10, 32'h2000_0001, 12'h000, 32'h0, 32'h5555_5555, 3'b100);
    flow("ld_misal", 32'h2000_0001, 32'h0, 4'b0010, 32'h0, 3'b100);

    // Back-to-back: address wraps past 2^32 with no fault of our own.
    issue(1'b0, 2'b00, 32'hFFFF_FFFF, 12'h002, 32'h0, 32'h0BAD_F00D, 3'b000);
    flow("ld_wrap", 32'h0000_0001, 32'h0, 4'b0000, 32'h0BAD_F00D, 3'b000);

    // Largest positive offset; code 011 has bit 2 clear so data passes.
    issue(1'b0, 2'b01, 32'h0000_1000, 12'h7FF, 32'h0, 32'hA5A5_0001, 3'b011);
    flow("ld_maxpos", 32'h0000_17FF, 32'h0, 4'b0001, 32'hA5A5_0001, 3'b011);

    // Most negative offset; store access fault 111.
    issue(1'b1, 2'b10, 32'h0000_1000, 12'h800, 32'hFEED_0042, 32'h7777_7777, 3'b111);
    flow("st_maxneg", 32'h0000_0800, 32'hFEED_0042, 4'b1010, 32'h0, 3'b111);
    tick();

    // Response stall with a waiting request, then immediate handoff.
    rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 32'h3000_0000, 12'h010, 32'h0, 32'h0102_0304, 3'b000);
    flow("stall_a", 32'h3000_0010, 32'h0, 4'b0010, 32'h0102_0304, 3'b000);
    issue(1'b0, 2'b10, 32'h3000_0100, 12'h020, 32'h0, 32'h0506_0708, 3'b101);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rv",    32'(rsp_valid), 32'd1);
      chk("stall_data",  rsp_data, 32'h0102_0304);
      chk("stall_fault", 32'(rsp_fault_num), 32'd0);
      chk("stall_addr",  rsp_addr, 32'h3000_0010);
      chk("stall_en",    32'(mem_enable_n), 32'd1);
      chk("stall_rdy",   32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_rdy", 32'(req_ready), 32'd1);
    flow("stall_b", 32'h3000_0120, 32'h0, 4'b0010, 32'h0, 3'b101);
    tick();

    // Reset while in SAMPLE discards the access.
    issue(1'b0, 2'b10, 32'h4000_0000, 12'h008, 32'h0, 32'h9999_9999, 3'b000);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rsmp_en", 32'(mem_enable_n), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rsmp_rdy_low", 32'(req_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rsmp_en_after", 32'(mem_enable_n), 32'd1);
    chk("rsmp_rdy",      32'(req_ready), 32'd1);
    chk("rsmp_addr",     rsp_addr, 32'd0);
    chk("rsmp_data",     rsp_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rsmp_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
